// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5) with a single-stage output
// register and a two-symbol zero tail that returns the trellis to state 00.
module conv_enc_k3 #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_pair,
  output logic             out_tail,
  output logic             out_last,
  output logic             len_err,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [1:0] ST_DATA  = 2'd0;
  localparam logic [1:0] ST_TAIL1 = 2'd1;
  localparam logic [1:0] ST_TAIL2 = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_sreg;
  logic             r_valid;
  logic [1:0]       r_pair;
  logic             r_tail;
  logic             r_last;
  logic             r_len_err;
  logic [CNT_W-1:0] r_cnt;

  logic       w_slot_free;
  logic       w_in_tail;
  logic       w_xfer;
  logic       w_load;
  logic       w_b;
  logic       w_at_max;
  logic [1:0] w_pair;

  assign w_slot_free = !r_valid || out_ready;
  assign w_in_tail   = (r_state == ST_TAIL1) || (r_state == ST_TAIL2);
  assign in_ready    = (r_state == ST_DATA) && w_slot_free;
  assign w_xfer      = in_valid && in_ready;
  assign w_load      = w_xfer || (w_in_tail && w_slot_free);
  // Tail symbols encode a forced zero input
  assign w_b         = (r_state == ST_DATA) ? in_bit : 1'b0;
  assign w_pair      = {w_b ^ r_sreg[1] ^ r_sreg[0], w_b ^ r_sreg[0]};
  assign w_at_max    = (r_cnt == CNT_W'(MAX_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pair  <= 2'b00;
      r_tail  <= 1'b0;
      r_last  <= 1'b0;
      r_sreg  <= 2'b00;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_pair  <= w_pair;
      r_tail  <= w_in_tail;
      r_last  <= (r_state == ST_TAIL2);
      r_sreg  <= {w_b, r_sreg[1]};
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_DATA;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else begin
      case (r_state)
        ST_DATA: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (in_last || w_at_max) r_state <= ST_TAIL1;
            if (w_at_max && !in_last) r_len_err <= 1'b1;
          end
        end
        ST_TAIL1: begin
          if (w_slot_free) r_state <= ST_TAIL2;
        end
        ST_TAIL2: begin
          if (w_slot_free) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_DATA;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_pair  = r_pair;
  assign out_tail  = r_tail;
  assign out_last  = r_last;
  assign len_err   = r_len_err;
  assign bit_cnt   = r_cnt;

endmodule

// File: tb/tb_conv_enc_k3.sv
// Bench for conv_enc_k3: frames are encoded by a sequence-level convolution model
// and compared symbol by symbol; a second instance runs with MAX_LEN=4.
module tb_conv_enc_k3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;

  logic       in_ready_a, out_valid_a, out_tail_a, out_last_a, len_err_a;
  logic [1:0] out_pair_a;
  logic [6:0] bit_cnt_a;
  logic       in_ready_b, out_valid_b, out_tail_b, out_last_b, len_err_b;
  logic [1:0] out_pair_b;
  logic [2:0] bit_cnt_b;

  conv_enc_k3 dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_pair(out_pair_a), .out_tail(out_tail_a),
    .out_last(out_last_a), .len_err(len_err_a), .bit_cnt(bit_cnt_a)
  );

  conv_enc_k3 #(.MAX_LEN(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_bit(in_bit), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_pair(out_pair_b), .out_tail(out_tail_b),
    .out_last(out_last_b), .len_err(len_err_b), .bit_cnt(bit_cnt_b)
  );

  logic       in_ready_m, out_valid_m, out_tail_m, out_last_m, len_err_m;
  logic [1:0] out_pair_m;
  logic [6:0] bit_cnt_m;
  assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
  assign out_valid_m = sel ? out_valid_b : out_valid_a;
  assign out_tail_m  = sel ? out_tail_b  : out_tail_a;
  assign out_last_m  = sel ? out_last_b  : out_last_a;
  assign len_err_m   = sel ? len_err_b   : len_err_a;
  assign out_pair_m  = sel ? out_pair_b  : out_pair_a;
  assign bit_cnt_m   = sel ? {4'b0, bit_cnt_b} : bit_cnt_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int hold_viol = 0;
  int irdy_viol = 0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_sym = '0;
  logic [3:0] col_q[$];
  int         col_cyc[$];
  logic [3:0] exp_q[$];
  logic       fb[$];
  logic       fl[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always, 1 = pattern 1,0,0, 2 = random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = (cyc % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && ({out_valid_m, out_pair_m, out_tail_m, out_last_m} !== prev_sym))
        hold_viol++;
      if (out_valid_m && !out_ready && in_ready_m) irdy_viol++;
      if (out_valid_m && out_ready) begin
        col_q.push_back({out_pair_m, out_tail_m, out_last_m});
        col_cyc.push_back(cyc);
      end
      prev_stall = out_valid_m && !out_ready;
      prev_sym   = {out_valid_m, out_pair_m, out_tail_m, out_last_m};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // bits[i] is the i-th bit in time order; expected symbols come from a
  // direct convolution of the zero-padded frame with 111 and 101.
  task automatic push_frame(input logic [31:0] bits, input int len, input bit with_last);
    logic u[$];
    logic a, p1, p2;
    for (int i = 0; i < len; i++) begin
      fb.push_back(bits[i]);
      fl.push_back(with_last && (i == len - 1));
      u.push_back(bits[i]);
    end
    u.push_back(1'b0);
    u.push_back(1'b0);
    for (int i = 0; i < len + 2; i++) begin
      a  = u[i];
      p1 = (i >= 1) ? u[i-1] : 1'b0;
      p2 = (i >= 2) ? u[i-2] : 1'b0;
      exp_q.push_back({a ^ p1 ^ p2, a ^ p2, (i >= len) ? 1'b1 : 1'b0, (i == len + 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic drive_bits(output bit ok);
    bit acc;
    int n;
    ok = 1'b1;
    for (int i = 0; i < fb.size(); i++) begin
      in_valid = 1'b1;
      in_bit   = fb[i];
      in_last  = fl[i];
      n = 0;
      do begin
        @(negedge clk);
        acc = in_ready_m;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 200);
      if (!acc) ok = 1'b0;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
    fb.delete();
    fl.delete();
  endtask

  task automatic run_frames(output bit ok);
    int k;
    drive_bits(ok);
    k = 0;
    while (col_q.size() < exp_q.size() && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (col_q.size() < exp_q.size()) ok = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    col_q.delete();
    col_cyc.delete();
    exp_q.delete();
    hold_viol = 0;
    irdy_viol = 0;
  endtask

  task automatic test_reset();
    rdy_mode = 0;
    do_reset();
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid_m); end
    checks++; if (out_pair_m !== 2'b00) begin errors++; $display("FAIL reset_out_pair got %b want 00", out_pair_m); end
    checks++; if (out_tail_m !== 1'b0) begin errors++; $display("FAIL reset_out_tail got %b want 0", out_tail_m); end
    checks++; if (out_last_m !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last_m); end
    checks++; if (len_err_m !== 1'b0) begin errors++; $display("FAIL reset_len_err got %b want 0", len_err_m); end
    checks++; if (bit_cnt_m !== 7'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt_m); end
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_m); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame(input string name, input int mode);
    bit ok;
    rdy_mode = mode;
    do_reset();
    push_frame(32'b1101, 4, 1'b1);
    run_frames(ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout got %0d symbols want %0d", name, col_q.size(), exp_q.size()); end
    checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count got %0d want %0d", name, col_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < col_q.size()) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_sym%0d got %b want %b", name, i, col_q[i], exp_q[i]); end
    end
    checks++; if (bit_cnt_m !== 7'd0) begin errors++; $display("FAIL %s_bit_cnt got %0d want 0", name, bit_cnt_m); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL %s_hold got %0d want 0", name, hold_viol); end
    checks++; if (irdy_viol != 0) begin errors++; $display("FAIL %s_in_ready_stall got %0d want 0", name, irdy_viol); end
  endtask

  task automatic test_single_bit();
    bit ok;
    rdy_mode = 0;
    do_reset();
    push_frame(32'b1, 1, 1'b1);
    push_frame(32'b10, 2, 1'b1);
    run_frames(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d want %0d", col_q.size(), exp_q.size()); end
    checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count got %0d want %0d", col_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < col_q.size()) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_sym%0d got %b want %b", i, col_q[i], exp_q[i]); end
    end
    for (int i = 1; i < col_cyc.size(); i++) begin
      checks++;
      if (col_cyc[i] - col_cyc[i-1] != 1) begin errors++; $display("FAIL single_gap%0d got %0d want 1", i, col_cyc[i] - col_cyc[i-1]); end
    end
  endtask

  task automatic test_max_len();
    bit ok;
    sel = 1'b1;
    rdy_mode = 0;
    do_reset();
    push_frame(32'b1111, 4, 1'b0);
    run_frames(ok);
    checks++; if (!ok) begin errors++; $display("FAIL maxlen_timeout got %0d want %0d", col_q.size(), exp_q.size()); end
    checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL maxlen_count got %0d want %0d", col_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < col_q.size()) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxlen_sym%0d got %b want %b", i, col_q[i], exp_q[i]); end
    end
    checks++; if (len_err_m !== 1'b1) begin errors++; $display("FAIL maxlen_len_err got %b want 1", len_err_m); end
    col_q.delete();
    col_cyc.delete();
    exp_q.delete();
    push_frame(32'b01, 2, 1'b1);
    run_frames(ok);
    checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL maxlen_next_count got %0d want %0d", col_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < col_q.size()) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxlen_next_sym%0d got %b want %b", i, col_q[i], exp_q[i]); end
    end
    checks++; if (len_err_m !== 1'b1) begin errors++; $display("FAIL maxlen_sticky got %b want 1", len_err_m); end
    rst = 1'b1;
    sel = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    rdy_mode = 0;
    do_reset();
    fb.push_back(1'b1); fl.push_back(1'b0);
    fb.push_back(1'b0); fl.push_back(1'b0);
    drive_bits(ok);
    @(negedge clk);
    checks++; if (bit_cnt_m !== 7'd2) begin errors++; $display("FAIL midrst_bit_cnt_before got %0d want 2", bit_cnt_m); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    col_q.delete();
    col_cyc.delete();
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid_m); end
    checks++; if (out_pair_m !== 2'b00) begin errors++; $display("FAIL midrst_out_pair got %b want 00", out_pair_m); end
    checks++; if (bit_cnt_m !== 7'd0) begin errors++; $display("FAIL midrst_bit_cnt got %0d want 0", bit_cnt_m); end
    checks++; if (in_ready_m !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready_m); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (col_q.size() != 0) begin errors++; $display("FAIL midrst_no_tail got %0d symbols want 0", col_q.size()); end
    push_frame(32'b1101, 4, 1'b1);
    run_frames(ok);
    checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", col_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < col_q.size()) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_sym%0d got %b want %b", i, col_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    rdy_mode = 0;
    do_reset();
    push_frame(32'b01, 2, 1'b1);
    push_frame(32'b10, 2, 1'b1);
    run_frames(ok);
    checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", col_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < col_q.size()) begin
      checks++;
      if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_sym%0d got %b want %b", i, col_q[i], exp_q[i]); end
    end
    for (int i = 1; i < col_cyc.size(); i++) begin
      checks++;
      if (col_cyc[i] - col_cyc[i-1] != 1) begin errors++; $display("FAIL b2b_gap%0d got %0d want 1", i, col_cyc[i] - col_cyc[i-1]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    rdy_mode = 2;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      col_q.delete();
      col_cyc.delete();
      exp_q.delete();
      hold_viol = 0;
      irdy_viol = 0;
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        len = int'($urandom_range(1, 20));
        push_frame($urandom(), len, 1'b1);
      end
      run_frames(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got %0d want %0d", r, col_q.size(), exp_q.size()); end
      checks++; if (col_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", r, col_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < col_q.size()) begin
        checks++;
        if (col_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_sym%0d got %b want %b", r, i, col_q[i], exp_q[i]); end
      end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_hold got %0d want 0", r, hold_viol); end
      checks++; if (irdy_viol != 0) begin errors++; $display("FAIL rand%0d_in_ready_stall got %0d want 0", r, irdy_viol); end
    end
    checks++; if (len_err_m !== 1'b0) begin errors++; $display("FAIL rand_len_err got %b want 0", len_err_m); end
  endtask

  initial begin
    test_reset();
    test_frame("basic", 0);
    test_frame("backpressure", 1);
    test_single_bit();
    test_max_len();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
